control: RTL and testbench

Control unit of the BIP1 accumulator processor: holds the program counter and decodes the current 16-bit instruction into datapath control strobes. Sits between program memory (it drives the instruction address and receives the fetched instruction) and the datapath (accumulator, ALU, data RAM), to which it supplies the operand field and the select/write/read controls.

---
 rtl/control.sv | 100 ++++++++++
 tb/tb_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/control.sv
// control: BIP1 control unit. Holds the program counter and decodes the current
// instruction into accumulator, ALU and data RAM strobes.
`default_nettype none

module control #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADRR    = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_INSTRUC-1:0] i_instruc,
    output logic [NB_OPERAND-1:0] o_operand,
    output logic [NB_ADRR-1:0]    o_addr,
    output logic [1:0]            o_SelA,
    output logic                  o_SelB,
    output logic                  o_WrAcc,
    output logic                  o_op,
    output logic                  o_WrRam,
    output logic                  o_RdRam
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    logic [NB_OPCODE-1:0] opcode;
    logic                 wr_pc;
    logic [NB_ADRR-1:0]   pc_q;
    logic [NB_ADRR-1:0]   pc_d;

    assign opcode    = i_instruc[NB_INSTRUC-1 -: NB_OPCODE];
    assign o_operand = i_instruc[NB_OPERAND-1:0];
    assign o_addr    = pc_q;

    always_comb begin
        o_SelA  = 2'b00;
        o_SelB  = 1'b0;
        o_WrAcc = 1'b0;
        o_op    = 1'b0;
        o_WrRam = 1'b0;
        o_RdRam = 1'b0;
        wr_pc   = 1'b1;
        case (opcode)
            OP_HLT:  wr_pc = 1'b0;
            OP_STO:  o_WrRam = 1'b1;
            OP_LD: begin
                o_WrAcc = 1'b1;
                o_RdRam = 1'b1;
            end
            OP_LDI: begin
                o_SelA  = 2'b01;
                o_WrAcc = 1'b1;
            end
            OP_ADD: begin
                o_SelA  = 2'b10;
                o_WrAcc = 1'b1;
                o_RdRam = 1'b1;
            end
            OP_ADDI: begin
                o_SelA  = 2'b10;
                o_SelB  = 1'b1;
                o_WrAcc = 1'b1;
            end
            OP_SUB: begin
                o_SelA  = 2'b10;
                o_WrAcc = 1'b1;
                o_op    = 1'b1;
                o_RdRam = 1'b1;
            end
            OP_SUBI: begin
                o_SelA  = 2'b10;
                o_SelB  = 1'b1;
                o_WrAcc = 1'b1;
                o_op    = 1'b1;
            end
            default: ;  // unassigned opcodes execute as NOP and still advance the PC
        endcase
    end

    // Increment wraps naturally at the register width.
    assign pc_d = wr_pc ? pc_q + NB_ADRR'(1) : pc_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for the BIP1 control unit.
`default_nettype none

module tb_control;

    logic        clk;
    logic        rst;
    logic [15:0] instruc;
    logic [10:0] operand;
    logic [10:0] addr;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        wr_ram;
    logic        rd_ram;

    int n_checks = 0;
    int n_errors = 0;

    control dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_instruc (instruc),
        .o_operand (operand),
        .o_addr    (addr),
        .o_SelA    (sel_a),
        .o_SelB    (sel_b),
        .o_WrAcc   (wr_acc),
        .o_op      (op),
        .o_WrRam   (wr_ram),
        .o_RdRam   (rd_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobes packed as {SelA[1:0], SelB, WrAcc, op, WrRam, RdRam}
    function automatic logic [6:0] strobes();
        return {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram};
    endfunction

    logic [15:0] dec_instr [9];
    logic [6:0]  dec_exp   [9];
    logic [10:0] addr_before;

    initial begin
        dec_instr[0] = 16'h0000; dec_exp[0] = 7'b00_0_0_0_0_0;  // HLT
        dec_instr[1] = 16'h0800; dec_exp[1] = 7'b00_0_0_0_1_0;  // STO
        dec_instr[2] = 16'h1000; dec_exp[2] = 7'b00_0_1_0_0_1;  // LD
        dec_instr[3] = 16'h1800; dec_exp[3] = 7'b01_0_1_0_0_0;  // LDI
        dec_instr[4] = 16'h2000; dec_exp[4] = 7'b10_0_1_0_0_1;  // ADD
        dec_instr[5] = 16'h2800; dec_exp[5] = 7'b10_1_1_0_0_0;  // ADDI
        dec_instr[6] = 16'h3000; dec_exp[6] = 7'b10_0_1_1_0_1;  // SUB
        dec_instr[7] = 16'h3800; dec_exp[7] = 7'b10_1_1_1_0_0;  // SUBI
        dec_instr[8] = 16'hF800; dec_exp[8] = 7'b00_0_0_0_0_0;  // undefined -> NOP

        // Reset is asynchronous: PC is 0 before any clock edge
        rst     = 1'b1;
        instruc = 16'h0800;
        #3;
        check("reset_async_addr", 32'(addr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_held_addr", 32'(addr), 32'h0);
        end

        // Decoder is live during reset
        instruc = 16'h2800;
        #1;
        check("decode_in_reset", 32'(strobes()), 32'(7'b10_1_1_0_0_0));
        instruc = 16'h0800;

        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_incr", 32'(addr), 32'(i));
        end

        // HLT freezes the PC
        instruc = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("halt_hold", 32'(addr), 32'h3);
        end
        instruc = 16'h2000;
        @(posedge clk); #1;
        check("halt_resume", 32'(addr), 32'h4);

        // Combinational decode sweep
        for (int i = 0; i < 9; i++) begin
            instruc = dec_instr[i];
            #1;
            check($sformatf("decode_%04h", dec_instr[i]), 32'(strobes()), 32'(dec_exp[i]));
            check("decode_operand_zero", 32'(operand), 32'h0);
        end

        // Undefined opcode still advances the PC
        @(negedge clk);
        instruc     = 16'hF800;
        addr_before = addr;
        @(posedge clk); #1;
        check("nop_incr", 32'(addr), 32'(addr_before + 11'd1));

        // Operand pass-through
        instruc = 16'h1D55;
        #1;
        check("ldi_operand", 32'(operand), 32'h555);
        check("ldi_sela", 32'(sel_a), 32'h1);
        check("ldi_wracc", 32'(wr_acc), 32'h1);

        // Reset asserted mid-cycle overrides any pending increment
        @(negedge clk);
        instruc = 16'h2000;
        #2;
        rst = 1'b1;
        #1;
        check("midcycle_reset_addr", 32'(addr), 32'h0);
        @(posedge clk); #1;
        check("midcycle_reset_hold", 32'(addr), 32'h0);

        // Wrap-around with continuous ADD
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2047; i++) @(posedge clk);
        #1;
        check("wrap_top", 32'(addr), 32'h7FF);
        @(posedge clk); #1;
        check("wrap_zero", 32'(addr), 32'h0);
        @(posedge clk); #1;
        check("wrap_next", 32'(addr), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
